// File: rtl/mem_port_arb.sv
// mem_port_arb: shares one Avalon-style memory command port between a writer
// client (c0) and a reader client (c1). Grants are handed out in bursts of at
// most BURST_LEN accepted commands, with exactly one IDLE cycle between grants.
// A small tag FIFO remembers which client issued each outstanding read, so that
// returned data is steered to the right client in order.
// Optional build macro: MEM_ARB_PRIO0_EN (client 0 wins every arbitration).
module mem_port_arb #(
  parameter int ADDR_W    = 29,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 8,
  parameter int TAG_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c0_wr_req,
  input  logic              c0_rd_req,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wr_data,
  output logic              c0_ack,
  output logic [DATA_W-1:0] c0_rd_data,
  output logic              c0_rd_valid,
  input  logic              c1_wr_req,
  input  logic              c1_rd_req,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wr_data,
  output logic              c1_ack,
  output logic [DATA_W-1:0] c1_rd_data,
  output logic              c1_rd_valid,
  input  logic              avl_ready,
  output logic              avl_write_req,
  output logic              avl_read_req,
  output logic [ADDR_W-1:0] avl_addr,
  output logic [DATA_W-1:0] avl_wdata,
  input  logic [DATA_W-1:0] avl_rd_data,
  input  logic              avl_rd_valid,
  output logic [1:0]        grant,
  output logic              err
);

  localparam int              PTR_W   = $clog2(TAG_DEPTH);
  localparam logic [PTR_W:0]  FULL_C  = (PTR_W+1)'(TAG_DEPTH);
  localparam logic [7:0]      BURST_C = 8'(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t             state_q;
  logic               last_q;
  logic [7:0]         cnt_q;
  logic [1:0]         grant_q;

  logic               tag_q [TAG_DEPTH];
  logic [PTR_W-1:0]   wptr_q;
  logic [PTR_W-1:0]   rptr_q;
  logic [PTR_W:0]     fill_q;
  logic               err_q;
  logic               rv0_q;
  logic               rv1_q;
  logic [DATA_W-1:0]  rd_data_q;

  logic               owner_s;
  logic               own_req_s;
  logic               wr_req_s;
  logic               rd_req_s;
  logic [ADDR_W-1:0]  addr_s;
  logic [DATA_W-1:0]  wdata_s;
  logic               full_s;
  logic               empty_s;
  logic               accept_s;
  logic               last_acc_s;
  logic               push_s;
  logic               pop_s;
  logic               req0_s;
  logic               req1_s;
  logic               pick0_s;
  logic               pick1_s;

  // Steer the owner's command onto the memory bus and decide the next owner.
  always_comb begin
    owner_s   = 1'b0;
    own_req_s = 1'b0;
    wr_req_s  = 1'b0;
    rd_req_s  = 1'b0;
    addr_s    = '0;
    wdata_s   = '0;
    full_s    = (fill_q == FULL_C);
    empty_s   = (fill_q == '0);
    req0_s    = c0_wr_req | c0_rd_req;
    req1_s    = c1_wr_req | c1_rd_req;
    case (state_q)
      G0: begin
        owner_s   = 1'b0;
        own_req_s = req0_s;
        wr_req_s  = c0_wr_req;
        rd_req_s  = c0_rd_req & ~c0_wr_req & ~full_s;
        addr_s    = c0_addr;
        wdata_s   = c0_wr_data;
      end
      G1: begin
        owner_s   = 1'b1;
        own_req_s = req1_s;
        wr_req_s  = c1_wr_req;
        rd_req_s  = c1_rd_req & ~c1_wr_req & ~full_s;
        addr_s    = c1_addr;
        wdata_s   = c1_wr_data;
      end
      default: begin
        owner_s   = 1'b0;
        own_req_s = 1'b0;
      end
    endcase
    accept_s   = avl_ready & (wr_req_s | rd_req_s);
    last_acc_s = accept_s & ((cnt_q + 8'd1) == BURST_C);
    push_s     = accept_s & rd_req_s;
    pop_s      = avl_rd_valid & ~empty_s;
`ifdef MEM_ARB_PRIO0_EN
    pick1_s    = req1_s & ~req0_s;
`else
    // With both requesting, the client that did not own the port last wins.
    pick1_s    = req1_s & (~req0_s | ~last_q);
`endif
    pick0_s    = req0_s & ~pick1_s;
  end

  assign avl_write_req = wr_req_s;
  assign avl_read_req  = rd_req_s;
  assign avl_addr      = addr_s;
  assign avl_wdata     = wdata_s;
  assign c0_ack        = accept_s & (state_q == G0);
  assign c1_ack        = accept_s & (state_q == G1);
  assign grant         = grant_q;
  assign err           = err_q;
  assign c0_rd_valid   = rv0_q;
  assign c1_rd_valid   = rv1_q;
  assign c0_rd_data    = rd_data_q;
  assign c1_rd_data    = rd_data_q;

  // Grant FSM: arbitration in IDLE, burst counting and release while granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= 8'd0;
          if (pick0_s) begin
            state_q <= G0;
            grant_q <= 2'b01;
          end else if (pick1_s) begin
            state_q <= G1;
            grant_q <= 2'b10;
          end else begin
            state_q <= IDLE;
            grant_q <= 2'b00;
          end
        end
        G0, G1: begin
          if (!own_req_s || last_acc_s) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= owner_s;
            cnt_q   <= 8'd0;
          end else if (accept_s) begin
            cnt_q <= cnt_q + 8'd1;
          end else begin
            cnt_q <= cnt_q;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= 2'b00;
          cnt_q   <= 8'd0;
        end
      endcase
    end
  end

  // Read-owner tag FIFO and registered read-return steering.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      fill_q    <= '0;
      err_q     <= 1'b0;
      rv0_q     <= 1'b0;
      rv1_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      if (push_s) begin
        tag_q[wptr_q] <= owner_s;
        wptr_q        <= wptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rptr_q <= rptr_q + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   fill_q <= fill_q + (PTR_W+1)'(1);
        2'b01:   fill_q <= fill_q - (PTR_W+1)'(1);
        default: fill_q <= fill_q;
      endcase
      rv0_q <= pop_s & ~tag_q[rptr_q];
      rv1_q <= pop_s & tag_q[rptr_q];
      if (avl_rd_valid) begin
        rd_data_q <= avl_rd_data;
      end
      // Data with no matching outstanding read is an orphan; flag it for good.
      if (avl_rd_valid && empty_s) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: directed scenarios followed by random traffic, all
// checked every cycle against a transaction-level reference model.
module tb_mem_port_arb;
  localparam int AW = 29;
  localparam int DW = 32;
  localparam int BL = 4;
  localparam int TD = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          c0_wr_req, c0_rd_req, c1_wr_req, c1_rd_req;
  logic [AW-1:0] c0_addr, c1_addr;
  logic [DW-1:0] c0_wr_data, c1_wr_data;
  logic          c0_ack, c1_ack, c0_rd_valid, c1_rd_valid;
  logic [DW-1:0] c0_rd_data, c1_rd_data;
  logic          avl_ready, avl_write_req, avl_read_req, avl_rd_valid;
  logic [AW-1:0] avl_addr;
  logic [DW-1:0] avl_wdata, avl_rd_data;
  logic [1:0]    grant;
  logic          err;

  mem_port_arb #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .TAG_DEPTH(TD)) dut (
    .clk(clk), .reset(reset),
    .c0_wr_req(c0_wr_req), .c0_rd_req(c0_rd_req), .c0_addr(c0_addr),
    .c0_wr_data(c0_wr_data), .c0_ack(c0_ack), .c0_rd_data(c0_rd_data),
    .c0_rd_valid(c0_rd_valid),
    .c1_wr_req(c1_wr_req), .c1_rd_req(c1_rd_req), .c1_addr(c1_addr),
    .c1_wr_data(c1_wr_data), .c1_ack(c1_ack), .c1_rd_data(c1_rd_data),
    .c1_rd_valid(c1_rd_valid),
    .avl_ready(avl_ready), .avl_write_req(avl_write_req), .avl_read_req(avl_read_req),
    .avl_addr(avl_addr), .avl_wdata(avl_wdata), .avl_rd_data(avl_rd_data),
    .avl_rd_valid(avl_rd_valid), .grant(grant), .err(err)
  );

  int errors = 0;
  int checks = 0;

  // reference model: owner (-1 idle), accepts used in this grant, last owner,
  // queue of outstanding read owners, sticky error and registered returns
  int            m_owner, m_used, m_last;
  int            m_q[$];
  bit            m_err, m_rv0, m_rv1;
  logic [DW-1:0] m_rdata;
  bit            p_wr, p_rd, p_ack0, p_ack1;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;

  // client stimulus state
  int            c_n[2];
  bit            c_rd[2];
  logic [AW-1:0] c_addr[2];
  logic [DW-1:0] c_data[2];
  bit            rnd_mode;
  int            tot_a0, tot_a1;
  logic [1:0]    hist_g[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void drive();
    c0_wr_req  = (c_n[0] > 0) && !c_rd[0];
    c0_rd_req  = (c_n[0] > 0) && c_rd[0];
    c0_addr    = c_addr[0];
    c0_wr_data = c_data[0];
    c1_wr_req  = (c_n[1] > 0) && !c_rd[1];
    c1_rd_req  = (c_n[1] > 0) && c_rd[1];
    c1_addr    = c_addr[1];
    c1_wr_data = c_data[1];
  endfunction

  function automatic void set_cmd(input int i, input int n, input bit rd, input logic [AW-1:0] a);
    c_n[i]    = n;
    c_rd[i]   = rd;
    c_addr[i] = a;
    c_data[i] = $urandom;
    drive();
  endfunction

  function automatic void client_adv(input int i, input bit acked);
    if (acked) begin
      c_n[i]--;
      c_addr[i] = c_addr[i] + AW'(1);
      c_data[i] = $urandom;
      if (rnd_mode) c_rd[i] = 1'($urandom_range(0, 1));
    end else if (rnd_mode && c_n[i] == 0 && $urandom_range(0, 2) == 0) begin
      c_n[i]    = int'($urandom_range(1, 6));
      c_rd[i]   = 1'($urandom_range(0, 1));
      c_addr[i] = AW'($urandom);
      c_data[i] = $urandom;
    end
  endfunction

  function automatic void model_reset();
    m_owner = -1; m_used = 0; m_last = 1;
    m_q.delete();
    m_err = 1'b0; m_rv0 = 1'b0; m_rv1 = 1'b0; m_rdata = '0;
  endfunction

  function automatic void predict();
    bit w, r;
    w = 1'b0; r = 1'b0;
    p_wr = 1'b0; p_rd = 1'b0; p_ack0 = 1'b0; p_ack1 = 1'b0;
    p_addr = '0; p_wdata = '0;
    if (m_owner == 0) begin
      w = c0_wr_req; r = c0_rd_req; p_addr = c0_addr; p_wdata = c0_wr_data;
    end else if (m_owner == 1) begin
      w = c1_wr_req; r = c1_rd_req; p_addr = c1_addr; p_wdata = c1_wr_data;
    end
    if (m_owner >= 0) begin
      p_wr = w;
      p_rd = r && !w && (m_q.size() < TD);
      if (avl_ready && (p_wr || p_rd)) begin
        if (m_owner == 0) p_ack0 = 1'b1;
        else p_ack1 = 1'b1;
      end
    end
  endfunction

  function automatic void model_edge();
    bit acc, q0, q1, rq;
    int o;
    if (reset) begin
      model_reset();
    end else begin
      acc = avl_ready && (p_wr || p_rd);
      q0  = c0_wr_req || c0_rd_req;
      q1  = c1_wr_req || c1_rd_req;
      m_rv0 = 1'b0; m_rv1 = 1'b0;
      if (avl_rd_valid) begin
        m_rdata = avl_rd_data;
        if (m_q.size() == 0) m_err = 1'b1;
        else begin
          o = m_q.pop_front();
          if (o == 0) m_rv0 = 1'b1;
          else m_rv1 = 1'b1;
        end
      end
      if (acc && p_rd) m_q.push_back(m_owner);
      if (m_owner < 0) begin
        m_used = 0;
`ifdef MEM_ARB_PRIO0_EN
        if (q0) m_owner = 0;
        else if (q1) m_owner = 1;
`else
        if (q0 && q1) m_owner = (m_last == 1) ? 0 : 1;
        else if (q0) m_owner = 0;
        else if (q1) m_owner = 1;
`endif
      end else begin
        rq = (m_owner == 0) ? q0 : q1;
        if (!rq || (acc && m_used + 1 == BL)) begin
          m_last  = m_owner;
          m_owner = -1;
          m_used  = 0;
        end else if (acc) begin
          m_used++;
        end
      end
    end
  endfunction

  // one clock: check the command bus mid-cycle, advance, check registered outputs
  task automatic step();
    bit a0, a1;
    logic [1:0] eg;
    #2;
    predict();
    chk("cmd_strobes", 64'({avl_write_req, avl_read_req, c0_ack, c1_ack}),
        64'({p_wr, p_rd, p_ack0, p_ack1}));
    chk("avl_addr", 64'(avl_addr), 64'(p_addr));
    chk("avl_wdata", 64'(avl_wdata), 64'(p_wdata));
    a0 = c0_ack; a1 = c1_ack;
    @(posedge clk);
    model_edge();
    #1;
    eg = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
    chk("grant", 64'(grant), 64'(eg));
    chk("rd_valid", 64'({c1_rd_valid, c0_rd_valid}), 64'({m_rv1, m_rv0}));
    chk("err", 64'(err), 64'(m_err));
    if (m_rv0 || m_rv1) begin
      chk("c0_rd_data", 64'(c0_rd_data), 64'(m_rdata));
      chk("c1_rd_data", 64'(c1_rd_data), 64'(m_rdata));
    end
    hist_g.push_back(grant);
    tot_a0 += int'(a0);
    tot_a1 += int'(a1);
    if (!reset) begin
      client_adv(0, a0);
      client_adv(1, a1);
      drive();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    c_n[0] = 0; c_n[1] = 0;
    drive();
    avl_rd_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    hist_g.delete();
    tot_a0 = 0; tot_a1 = 0;
  endtask

  logic [DW-1:0] ret_data[3];
  logic [1:0]    ret_exp[3];
  logic [1:0]    eg2;

  initial begin
    rnd_mode = 1'b0;
    reset = 1'b1;
    avl_ready = 1'b1; avl_rd_valid = 1'b0; avl_rd_data = '0;
    c_n[0] = 0; c_n[1] = 0; c_rd[0] = 1'b0; c_rd[1] = 1'b0;
    c_addr[0] = '0; c_addr[1] = '0; c_data[0] = '0; c_data[1] = '0;
    drive();
    tot_a0 = 0; tot_a1 = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // reset state
    do_reset();
    chk("reset_outputs", 64'({grant, err, c0_rd_valid, c1_rd_valid, avl_write_req,
        avl_read_req, c0_ack, c1_ack}), 64'd0);
    chk("reset_rd_data", 64'({c0_rd_data, c1_rd_data}), 64'd0);
    chk("reset_avl_bus", 64'({avl_addr, avl_wdata}), 64'd0);

    // client 0 writes three words at address 0..2
    set_cmd(0, 3, 1'b0, AW'(0));
    repeat (8) step();
    chk("t1_grant_next_cycle", 64'(hist_g[0]), 64'd1);
    chk("t1_grant_third_ack", 64'(hist_g[3]), 64'd1);
    chk("t1_idle_after_drop", 64'(hist_g[4]), 64'd0);
    chk("t1_ack_count", 64'(tot_a0), 64'd3);

    // both clients busy: bursts of BL separated by one idle cycle
    do_reset();
    set_cmd(0, 100, 1'b0, AW'(32'h100));
    set_cmd(1, 100, 1'b0, AW'(32'h200));
    repeat (20) step();
    for (int k = 0; k < 20; k++) begin
`ifdef MEM_ARB_PRIO0_EN
      eg2 = (k % 5 == 4) ? 2'b00 : 2'b01;
`else
      eg2 = (k % 5 == 4) ? 2'b00 : (((k / 5) % 2 == 0) ? 2'b01 : 2'b10);
`endif
      chk("t2_grant_seq", 64'(hist_g[k]), 64'(eg2));
    end
`ifdef MEM_ARB_PRIO0_EN
    chk("t2_acks0", 64'(tot_a0), 64'd16);
    chk("t2_acks1", 64'(tot_a1), 64'd0);
`else
    chk("t2_acks0", 64'(tot_a0), 64'd8);
    chk("t2_acks1", 64'(tot_a1), 64'd8);
`endif

    // client 1 fills the tag FIFO; 9th read stalls, client 0 write still served
    do_reset();
    set_cmd(1, 9, 1'b1, AW'(32'h300));
    repeat (3) step();
    set_cmd(0, 1, 1'b0, AW'(32'h400));
    repeat (27) step();
    chk("t3_reads_acked", 64'(tot_a1), 64'd8);
    chk("t3_write_acked", 64'(tot_a0), 64'd1);
    chk("t3_stall", 64'({grant, c1_rd_req, avl_read_req, c1_ack}), 64'({2'b10, 3'b100}));
    for (int k = 0; k < 9; k++) begin
      avl_rd_valid = 1'b1;
      avl_rd_data  = $urandom;
      step();
    end
    avl_rd_valid = 1'b0;
    repeat (2) step();
    chk("t3_ninth_read", 64'(tot_a1), 64'd9);

    // interleaved reads c0, c1, c0 return in order
    do_reset();
    set_cmd(0, 1, 1'b1, AW'(32'h10));
    set_cmd(1, 1, 1'b1, AW'(32'h20));
    repeat (6) step();
    set_cmd(0, 1, 1'b1, AW'(32'h30));
    repeat (6) step();
    ret_data[0] = 32'hA0A0_0001; ret_data[1] = 32'hB1B1_0002; ret_data[2] = 32'hC0C0_0003;
    ret_exp[0] = 2'b01; ret_exp[1] = 2'b10; ret_exp[2] = 2'b01;
    for (int k = 0; k < 3; k++) begin
      avl_rd_valid = 1'b1;
      avl_rd_data  = ret_data[k];
      step();
      chk("t4_return_owner", 64'({c1_rd_valid, c0_rd_valid}), 64'(ret_exp[k]));
      chk("t4_return_data", 64'(ret_exp[k][0] ? c0_rd_data : c1_rd_data), 64'(ret_data[k]));
    end
    avl_rd_valid = 1'b0;
    step();
    chk("t4_no_extra_valid", 64'({c1_rd_valid, c0_rd_valid}), 64'd0);

    // orphan return sets sticky err
    avl_rd_valid = 1'b1;
    avl_rd_data  = 32'hDEAD_BEEF;
    step();
    chk("t5_err_set", 64'({err, c1_rd_valid, c0_rd_valid}), 64'({1'b1, 2'b00}));
    avl_rd_valid = 1'b0;
    repeat (3) step();
    chk("t5_err_sticky", 64'(err), 64'd1);

    // reset during a G1 burst with three reads outstanding
    do_reset();
    chk("t6_err_cleared", 64'(err), 64'd0);
    set_cmd(1, 6, 1'b1, AW'(32'h500));
    repeat (4) step();
    chk("t6_in_g1", 64'({grant, 6'(tot_a1)}), 64'({2'b10, 6'd3}));
    reset = 1'b1;
    c_n[1] = 0;
    drive();
    step();
    chk("t6_idle_after_reset", 64'(grant), 64'd0);
    reset = 1'b0;
    set_cmd(0, 1, 1'b0, AW'(32'h600));
    set_cmd(1, 1, 1'b1, AW'(32'h700));
    for (int k = 0; k < 3; k++) begin
      avl_rd_valid = 1'b1;
      avl_rd_data  = $urandom;
      step();
      if (k == 0) chk("t6_c0_wins", 64'(grant), 64'd1);
      chk("t6_no_valid", 64'({c1_rd_valid, c0_rd_valid}), 64'd0);
    end
    avl_rd_valid = 1'b0;
    chk("t6_orphans_err", 64'(err), 64'd1);
    repeat (6) step();

    // random traffic against the model
    do_reset();
    rnd_mode = 1'b1;
    for (int k = 0; k < 500; k++) begin
      avl_ready    = ($urandom_range(0, 3) != 0);
      avl_rd_valid = ((m_q.size() > 0) && ($urandom_range(0, 1) == 1)) ||
                     ($urandom_range(0, 199) == 0);
      avl_rd_data  = $urandom;
      step();
    end
    rnd_mode = 1'b0;
    avl_rd_valid = 1'b0;
    c_n[0] = 0; c_n[1] = 0;
    drive();
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
